regfile_port_arbiter: RTL
=========================

# regfile_port_arbiter

- Parametrised, pipelined arbiter that shares one register-file port set (2 reads + 1 write) among NUM_CH execution units.
- Sits between the per-format execution units and the register file, replacing opcode-steered muxing.
- Units raise requests independently. A round-robin or fixed-priority arbiter grants one unit per cycle.
- Read data returns to the granted unit with a valid pulse; writes to x0 are suppressed.

## Interface
Parameters:
- NUM_CH, 6, number of requesting units (2..16)
- XLEN, 32, register data width
- AW, 5, register address width
- MODE, 0, arbitration: 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports (channel k occupies slice [k*W +: W] of each flattened bus):
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- i_REQ  in  NUM_CH  per-channel request
- i_RS1  in  NUM_CH*AW  per-channel read address 1
- i_RS2  in  NUM_CH*AW  per-channel read address 2
- i_WE  in  NUM_CH  per-channel write enable
- i_RD  in  NUM_CH*AW  per-channel write address
- i_WDATA  in  NUM_CH*XLEN  per-channel write data
- o_GNT  out  NUM_CH  one-hot grant, registered
- o_RVALID  out  NUM_CH  one-hot read-data valid, registered
- o_RDATA1  out  NUM_CH*XLEN  per-channel read data 1, held until next RVALID for that channel
- o_RDATA2  out  NUM_CH*XLEN  per-channel read data 2, held likewise
- o_X_RS1  out  AW  register-file read address 1
- o_X_RS2  out  AW  register-file read address 2
- o_X_RD  out  AW  register-file write address
- o_X_WE  out  1  register-file write enable
- o_X_REG_IN  out  XLEN  register-file write data
- i_X_REG_OUT1  in  XLEN  register-file read data 1 (combinational read)
- i_X_REG_OUT2  in  XLEN  register-file read data 2

## Operation
Arbitration:
- Eligible set = i_REQ & ~o_GNT. A channel holding the grant this cycle is masked from arbitration.
- MODE 0: search starts at ptr and wraps modulo NUM_CH; the first eligible channel wins. On a grant to k, ptr <= (k+1) mod NUM_CH. ptr is unchanged when idle.
- MODE 1: the lowest-index eligible channel wins. ptr is unused.
- At most one grant per cycle.

Issue stage (registered):
- On the edge that selects k:
  - o_GNT <= onehot(k).
  - o_X_RS1/RS2/RD/REG_IN <= channel k fields.
  - o_X_WE <= i_WE[k] & (i_RD[k] != 0).
- With no winner, o_GNT and o_X_WE are 0 and the address/data outputs hold their values.

Return stage:
- On the edge ending a cycle with o_GNT[k]=1:
  - o_RDATA1/2[k] <= i_X_REG_OUT1/2.
  - o_RVALID <= onehot(k).
- Otherwise o_RVALID is 0. The other channels' RDATA is untouched.

Requester rules:
- Hold REQ and all fields stable until o_GNT[k] is seen.
- By the edge ending the grant cycle, either drop REQ or present the next request.

Reset:
- All outputs 0, ptr = 0.
- An in-flight issue or return is discarded: no write and no RVALID after RST deasserts.

## Timing
- Latency, REQ sampled at edge E:
  - o_GNT and register-file controls are valid in cycle E+1.
  - Register-file write commits at edge E+2.
  - o_RVALID and RDATA are valid in cycle E+2.
- Throughput:
  - One transaction per cycle across channels.
  - One per 2 cycles for a single channel, due to grant masking.
- Same-cycle read and write to one address return the pre-write value; the arbiter does no forwarding.
- The x0 write suppression is decided at issue; RD=0 with WE=1 never asserts o_X_WE.
- All-requesting with MODE 0: grants rotate k, k+1, ... with no starvation. The worst-case wait is NUM_CH-1 grants.
- Reset asserted mid-cycle clears outputs immediately (asynchronous). Release is synchronous to the next CLK edge.

## Test plan
- Single request: ch2 REQ, RS1=3, RS2=4, reg3=0x11, reg4=0x22.
  - o_GNT=0b000100 and o_X_RS1=3 one cycle later.
  - o_RVALID[2]=1 with RDATA1=0x11, RDATA2=0x22 the next cycle.
- Round-robin fairness: MODE 0, all 6 channels hold REQ continuously for 12 cycles.
  - Grants go 0,1,2,3,4,5,0,... and each channel receives exactly 2 grants.
- Fixed priority: MODE 1, ch1 and ch4 request continuously.
  - Grants alternate 1,4,1,4, because grant masking lets ch4 in every other cycle.
- Write and x0: ch0 writes RD=5, WDATA=0xDEADBEEF, then ch3 writes RD=0.
  - o_X_WE=1 with o_X_RD=5 for the first; o_X_WE=0 for the second.
  - A later read of 5 returns 0xDEADBEEF.
- Reset mid-flight: assert RST in the grant cycle of ch1.
  - o_GNT, o_X_WE and o_RVALID go 0 immediately.
  - After release, no RVALID for ch1 and ptr=0, so the next grant goes to the lowest requester.
- Data hold: ch2 receives data, then ch5 is serviced.
  - o_RDATA1[2] keeps its value while o_RVALID[5] pulses.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one register-file port set (two reads, one
// write) among NUM_CH execution units. The arbiter grants one requester per
// cycle, using either round-robin or fixed priority. It drives the
// register-file controls in the grant cycle and returns the read data to the
// granted unit one cycle later, together with a one-hot valid pulse.
module regfile_port_arbiter #(
    parameter int NUM_CH = 6,
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int MODE   = 0     // 0 = round-robin, 1 = fixed priority (ch0 highest)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_CH-1:0]      i_REQ,
    input  logic [NUM_CH*AW-1:0]   i_RS1,
    input  logic [NUM_CH*AW-1:0]   i_RS2,
    input  logic [NUM_CH-1:0]      i_WE,
    input  logic [NUM_CH*AW-1:0]   i_RD,
    input  logic [NUM_CH*XLEN-1:0] i_WDATA,
    output logic [NUM_CH-1:0]      o_GNT,
    output logic [NUM_CH-1:0]      o_RVALID,
    output logic [NUM_CH*XLEN-1:0] o_RDATA1,
    output logic [NUM_CH*XLEN-1:0] o_RDATA2,
    output logic [AW-1:0]          o_X_RS1,
    output logic [AW-1:0]          o_X_RS2,
    output logic [AW-1:0]          o_X_RD,
    output logic                   o_X_WE,
    output logic [XLEN-1:0]        o_X_REG_IN,
    input  logic [XLEN-1:0]        i_X_REG_OUT1,
    input  logic [XLEN-1:0]        i_X_REG_OUT2
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Registered state
    logic [NUM_CH-1:0]      r_gnt;
    logic [NUM_CH-1:0]      r_rvalid;
    logic [NUM_CH*XLEN-1:0] r_rdata1;
    logic [NUM_CH*XLEN-1:0] r_rdata2;
    logic [AW-1:0]          r_x_rs1;
    logic [AW-1:0]          r_x_rs2;
    logic [AW-1:0]          r_x_rd;
    logic                   r_x_we;
    logic [XLEN-1:0]        r_x_reg_in;
    logic [PW-1:0]          r_ptr;

    // Arbitration results and the winner's fields
    logic [NUM_CH-1:0]      w_elig;
    logic                   w_found;
    logic [PW-1:0]          w_win;
    logic [NUM_CH-1:0]      w_win_oh;
    logic [PW-1:0]          w_ptr_next;
    logic [AW-1:0]          w_rs1;
    logic [AW-1:0]          w_rs2;
    logic [AW-1:0]          w_rd;
    logic [XLEN-1:0]        w_wdata;
    logic                   w_we;

    // A channel that holds the grant this cycle sits out one round. This
    // keeps a held request from being granted twice for one transaction.
    assign w_elig = i_REQ & ~r_gnt;

    // Pick the winner: scan from ptr (round-robin) or from 0 (fixed priority)
    always_comb begin
        int idx;
        // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (MODE == 1) begin
                idx = i;
            end else begin
                idx = int'(r_ptr) + i;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
            end
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_win_oh   = {{(NUM_CH-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_next = (w_win == PW'(NUM_CH - 1)) ? '0 : w_win + PW'(1);

    assign w_rs1   = i_RS1[w_win*AW +: AW];
    assign w_rs2   = i_RS2[w_win*AW +: AW];
    assign w_rd    = i_RD[w_win*AW +: AW];
    assign w_wdata = i_WDATA[w_win*XLEN +: XLEN];
    // x0 is hard-wired zero, so a write to it is dropped here at issue.
    assign w_we    = i_WE[w_win] & (w_rd != '0);

    // Issue stage: register the grant and drive the register-file controls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_gnt      <= '0;
            r_x_rs1    <= '0;
            r_x_rs2    <= '0;
            r_x_rd     <= '0;
            r_x_we     <= 1'b0;
            r_x_reg_in <= '0;
            r_ptr      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_gnt  <= '0;
            r_x_we <= 1'b0;
            if (w_found) begin
                r_gnt      <= w_win_oh;
                r_x_rs1    <= w_rs1;
                r_x_rs2    <= w_rs2;
                r_x_rd     <= w_rd;
                r_x_we     <= w_we;
                r_x_reg_in <= w_wdata;
                if (MODE == 0) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    // Return stage: capture the read data for the channel granted last cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rvalid <= '0;
            // NOTE: the per-channel data holding registers are reset too, so every output reads 0 after reset.
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            r_rvalid <= r_gnt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (r_gnt[k]) begin
                    r_rdata1[k*XLEN +: XLEN] <= i_X_REG_OUT1;
                    r_rdata2[k*XLEN +: XLEN] <= i_X_REG_OUT2;
                end
            end
        end
    end

    assign o_GNT      = r_gnt;
    assign o_RVALID   = r_rvalid;
    assign o_RDATA1   = r_rdata1;
    assign o_RDATA2   = r_rdata2;
    assign o_X_RS1    = r_x_rs1;
    assign o_X_RS2    = r_x_rs2;
    assign o_X_RD     = r_x_rd;
    assign o_X_WE     = r_x_we;
    assign o_X_REG_IN = r_x_reg_in;

endmodule
